// File: rtl/up_down_counter_pkg.sv
// -----------------------------------------------------------------------------
// up_down_counter_pkg
// Shared constants and types for the parameterised up/down counter.
//   MODE_WRAP / MODE_SAT : values for the counter's MODE_SAT parameter
//   PRESCALE_W           : width of the prescaler count register
//   action_e             : the single action taken on a falling edge,
//                          decoded in priority order clear > load > step > hold
// -----------------------------------------------------------------------------
package up_down_counter_pkg;

    localparam int MODE_WRAP  = 0;
    localparam int MODE_SAT   = 1;
    localparam int PRESCALE_W = 16;

    typedef enum logic [1:0] {
        ACT_HOLD  = 2'd0,
        ACT_STEP  = 2'd1,
        ACT_LOAD  = 2'd2,
        ACT_CLEAR = 2'd3
    } action_e;

endpackage : up_down_counter_pkg

// File: rtl/up_down_counter_param_prescale_tick.sv
// -----------------------------------------------------------------------------
// prescale_tick
// Divides enabled falling edges of Clk_In by PRESCALE and flags the edge on
// which a count step should happen.
//   Clk_In   in  : clock, state advances on the falling edge
//   Reset_In in  : asynchronous active-high reset, returns the count to 0
//   i_clear  in  : synchronous return of the count to 0 (wins over i_enable)
//   i_enable in  : advance the count on this edge; hold when low
//   o_tick   out : high during the cycle whose falling edge is a step edge
// o_tick is combinational from the registered count so the consumer can act
// on the very edge where the count wraps back to 0.
// -----------------------------------------------------------------------------
module prescale_tick
    import up_down_counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic Clk_In,
    input  logic Reset_In,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick
);

    generate
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("prescale_tick: PRESCALE must be in 1..65535");
        end
    endgenerate

    localparam logic [PRESCALE_W-1:0] LAST = PRESCALE_W'(PRESCALE - 1);

    logic [PRESCALE_W-1:0] r_count;
    logic                  w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_tick    = i_enable && w_at_last;

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + PRESCALE_W'(1);
            end
        end
    end

endmodule : prescale_tick

// File: rtl/up_down_counter_param.sv
// -----------------------------------------------------------------------------
// up_down_counter_param
// Prescaled up/down counter over 0..MAX_COUNT with wrap or saturate at the
// limits. All state changes on the falling edge of Clk_In.
//   Clk_In             in  : clock (falling edge active)
//   Reset_In           in  : asynchronous active-high reset
//   Start_Stopb_In     in  : 1 = count, 0 = hold (prescaler holds too)
//   Up_Downb_In        in  : 1 = up, 0 = down, sampled on step edges only
//   Clear_In           in  : synchronous clear of count, prescaler, flags
//   Load_In            in  : synchronous load of min(Load_Value_In, MAX_COUNT)
//   Load_Value_In      in  : [WIDTH-1:0] load value
//   Count_Out          out : [WIDTH-1:0] registered count
//   Terminal_Count_Out out : one-cycle pulse after a boundary step
//   Overflow_Out       out : sticky boundary flag, cleared by clear/reset
// A boundary step is an up step at MAX_COUNT or a down step at 0, whether
// the count wraps or saturates.
// -----------------------------------------------------------------------------
module up_down_counter_param #(
    parameter int              WIDTH     = 8,
    parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
    parameter int              MODE_SAT  = 0,
    parameter int              PRESCALE  = 1
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Start_Stopb_In,
    input  logic             Up_Downb_In,
    input  logic             Clear_In,
    input  logic             Load_In,
    input  logic [WIDTH-1:0] Load_Value_In,
    output logic [WIDTH-1:0] Count_Out,
    output logic             Terminal_Count_Out,
    output logic             Overflow_Out
);

    // The package constant of the same name as the MODE_SAT parameter is
    // reached through an explicit scope so the two never shadow each other.
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("up_down_counter_param: WIDTH must be in 2..32");
        end
        if (MAX_COUNT < 64'd1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
            $error("up_down_counter_param: MAX_COUNT must be in 1..2**WIDTH-1");
        end
        if (MODE_SAT != up_down_counter_pkg::MODE_WRAP &&
            MODE_SAT != up_down_counter_pkg::MODE_SAT) begin : g_bad_mode
            $error("up_down_counter_param: MODE_SAT must be 0 or 1");
        end
        if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
            $error("up_down_counter_param: PRESCALE must be in 1..65535");
        end
    endgenerate

    localparam logic [WIDTH-1:0] MAX_V      = MAX_COUNT[WIDTH-1:0];
    localparam bit               SATURATE   = (MODE_SAT == up_down_counter_pkg::MODE_SAT);

    logic [WIDTH-1:0]            r_count;
    logic                        r_terminal;
    logic                        r_overflow;

    logic                        w_enable;
    logic                        w_tick;
    logic                        w_at_max;
    logic                        w_at_zero;
    logic                        w_boundary;
    logic [WIDTH-1:0]            w_step_value;
    logic [WIDTH-1:0]            w_load_value;
    up_down_counter_pkg::action_e w_action;

    // Load also restarts the prescaler, so both clear and load reset it and
    // neither lets it advance on that edge.
    assign w_enable = Start_Stopb_In && !Clear_In && !Load_In;

    prescale_tick #(
        .PRESCALE (PRESCALE)
    ) u_prescale (
        .Clk_In   (Clk_In),
        .Reset_In (Reset_In),
        .i_clear  (Clear_In || Load_In),
        .i_enable (w_enable),
        .o_tick   (w_tick)
    );

    always_comb begin
        w_action = up_down_counter_pkg::ACT_HOLD;
        if (Clear_In) begin
            w_action = up_down_counter_pkg::ACT_CLEAR;
        end else if (Load_In) begin
            w_action = up_down_counter_pkg::ACT_LOAD;
        end else if (w_tick) begin
            w_action = up_down_counter_pkg::ACT_STEP;
        end
    end

    assign w_at_max   = (r_count == MAX_V);
    assign w_at_zero  = (r_count == '0);
    assign w_boundary = Up_Downb_In ? w_at_max : w_at_zero;

    always_comb begin
        w_step_value = r_count;
        if (Up_Downb_In) begin
            if (w_at_max) begin
                w_step_value = SATURATE ? MAX_V : '0;
            end else begin
                w_step_value = r_count + WIDTH'(1);
            end
        end else begin
            if (w_at_zero) begin
                w_step_value = SATURATE ? '0 : MAX_V;
            end else begin
                w_step_value = r_count - WIDTH'(1);
            end
        end
    end

    assign w_load_value = (Load_Value_In > MAX_V) ? MAX_V : Load_Value_In;

    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            r_count    <= '0;
            r_terminal <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            case (w_action)
                up_down_counter_pkg::ACT_CLEAR: begin
                    r_count    <= '0;
                    r_terminal <= 1'b0;
                    r_overflow <= 1'b0;
                end
                up_down_counter_pkg::ACT_LOAD: begin
                    r_count    <= w_load_value;
                    r_terminal <= 1'b0;
                end
                up_down_counter_pkg::ACT_STEP: begin
                    r_count    <= w_step_value;
                    r_terminal <= w_boundary;
                    if (w_boundary) begin
                        r_overflow <= 1'b1;
                    end
                end
                default: begin
                    r_terminal <= 1'b0;
                end
            endcase
        end
    end

    assign Count_Out          = r_count;
    assign Terminal_Count_Out = r_terminal;
    assign Overflow_Out       = r_overflow;

endmodule : up_down_counter_param

// File: tb/tb_up_down_counter_param.sv
module tb_up_down_counter_param;

    logic       clk = 1'b1;
    logic       rst;
    logic       start;
    logic       up;
    logic       clr;
    logic       load;
    logic [3:0] load_val;

    logic [3:0] w_cnt, s_cnt, p_cnt;
    logic       w_tc,  s_tc,  p_tc;
    logic       w_ovf, s_ovf, p_ovf;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       clr;
        logic       load;
        logic       start;
        logic       up;
        logic [3:0] val;
        logic [3:0] exp_cnt;
        logic       exp_tc;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- DUTs ----------------
    up_down_counter_param #(.WIDTH(4), .MAX_COUNT(9), .MODE_SAT(0), .PRESCALE(1)) dut_wrap (
        .Clk_In(clk), .Reset_In(rst), .Start_Stopb_In(start), .Up_Downb_In(up),
        .Clear_In(clr), .Load_In(load), .Load_Value_In(load_val),
        .Count_Out(w_cnt), .Terminal_Count_Out(w_tc), .Overflow_Out(w_ovf));

    up_down_counter_param #(.WIDTH(4), .MAX_COUNT(9), .MODE_SAT(1), .PRESCALE(1)) dut_sat (
        .Clk_In(clk), .Reset_In(rst), .Start_Stopb_In(start), .Up_Downb_In(up),
        .Clear_In(clr), .Load_In(load), .Load_Value_In(load_val),
        .Count_Out(s_cnt), .Terminal_Count_Out(s_tc), .Overflow_Out(s_ovf));

    up_down_counter_param #(.WIDTH(4), .MAX_COUNT(9), .MODE_SAT(0), .PRESCALE(3)) dut_pre (
        .Clk_In(clk), .Reset_In(rst), .Start_Stopb_In(start), .Up_Downb_In(up),
        .Clear_In(clr), .Load_In(load), .Load_Value_In(load_val),
        .Count_Out(p_cnt), .Terminal_Count_Out(p_tc), .Overflow_Out(p_ovf));

    // ---------------- driver tasks ----------------
    task automatic drive(input logic c, input logic l, input logic s,
                         input logic u, input logic [3:0] v);
        clr      = c;
        load     = l;
        start    = s;
        up       = u;
        load_val = v;
    endtask

    // Advance one active (falling) edge and settle just after it.
    task automatic edge_step();
        @(negedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic l, input logic s, input logic u,
                                input logic [3:0] v, input logic [3:0] ec,
                                input logic et, input logic eo);
        vec_t r;
        r.clr = c; r.load = l; r.start = s; r.up = u; r.val = v;
        r.exp_cnt = ec; r.exp_tc = et; r.exp_ovf = eo;
        return r;
    endfunction

    // ---------------- test ----------------
    initial begin
        // Table for the wrapping, undivided counter (dut_wrap).
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));          // clear
        for (int i = 1; i <= 9; i++) begin
            tbl.push_back(mk(0, 0, 1, 1, 0, 4'(i), 0, 0));  // count up 1..9
        end
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1));          // 9 -> 0 wrap
        tbl.push_back(mk(0, 0, 1, 1, 0, 1, 0, 1));          // pulse ends, flag sticky
        tbl.push_back(mk(0, 1, 1, 1, 12, 9, 0, 1));         // load clamped to 9
        tbl.push_back(mk(0, 0, 0, 1, 0, 9, 0, 1));          // stopped: hold
        tbl.push_back(mk(0, 1, 0, 0, 3, 3, 0, 1));          // load 3
        tbl.push_back(mk(0, 0, 1, 0, 0, 2, 0, 1));          // down
        tbl.push_back(mk(0, 0, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 0, 0, 9, 1, 1));          // 0 -> 9 wrap
        tbl.push_back(mk(0, 1, 0, 0, 5, 5, 0, 1));          // load 5
        tbl.push_back(mk(1, 1, 1, 1, 7, 0, 0, 0));          // clear beats load and tick
        tbl.push_back(mk(0, 1, 0, 0, 12, 9, 0, 0));         // load clamp, flag stays 0
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1));          // wrap from loaded max
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));          // stopped: pulse drops

        // Reset state, checked before any clock edge.
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        chk("reset_cnt", 32'(w_cnt), 0);
        chk("reset_tc",  32'(w_tc),  0);
        chk("reset_ovf", 32'(w_ovf), 0);
        #2;
        rst = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].clr, tbl[i].load, tbl[i].start, tbl[i].up, tbl[i].val);
            edge_step();
            chk($sformatf("tbl%0d_cnt", i), 32'(w_cnt), 32'(tbl[i].exp_cnt));
            chk($sformatf("tbl%0d_tc",  i), 32'(w_tc),  32'(tbl[i].exp_tc));
            chk($sformatf("tbl%0d_ovf", i), 32'(w_ovf), 32'(tbl[i].exp_ovf));
        end

        // Prescale by 3: 4 enabled edges, 4 stopped edges, 2 more enabled.
        drive(1, 0, 0, 0, 0);
        edge_step();
        chk("pre_clear_cnt", 32'(p_cnt), 0);
        begin
            logic [3:0] exp_pre[10];
            logic       en_pre[10];
            exp_pre = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 2};
            en_pre  = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1};
            for (int i = 0; i < 10; i++) begin
                drive(0, 0, en_pre[i], 1, 0);
                edge_step();
                chk($sformatf("pre%0d_cnt", i), 32'(p_cnt), 32'(exp_pre[i]));
                chk($sformatf("pre%0d_tc", i),  32'(p_tc),  0);
            end
        end

        // Saturating counter: down at 0 three times, then up at max twice.
        drive(1, 0, 0, 0, 0);
        edge_step();
        chk("sat_clear_ovf", 32'(s_ovf), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 0, 0);
            edge_step();
            chk($sformatf("sat_dn%0d_cnt", i), 32'(s_cnt), 0);
            chk($sformatf("sat_dn%0d_tc", i),  32'(s_tc),  1);
            chk($sformatf("sat_dn%0d_ovf", i), 32'(s_ovf), 1);
        end
        drive(0, 1, 0, 0, 9);
        edge_step();
        chk("sat_load_cnt", 32'(s_cnt), 9);
        chk("sat_load_tc",  32'(s_tc),  0);
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 1, 1, 0);
            edge_step();
            chk($sformatf("sat_up%0d_cnt", i), 32'(s_cnt), 9);
            chk($sformatf("sat_up%0d_tc", i),  32'(s_tc),  1);
        end
        drive(0, 0, 0, 1, 0);
        edge_step();
        chk("sat_hold_tc",  32'(s_tc),  0);
        chk("sat_hold_ovf", 32'(s_ovf), 1);

        // Asynchronous reset mid-period with the prescaler part-way through.
        drive(0, 1, 0, 0, 7);
        edge_step();
        chk("rst_load_cnt", 32'(p_cnt), 7);
        drive(0, 0, 1, 1, 0);
        edge_step();
        chk("rst_pre_cnt", 32'(p_cnt), 7);
        chk("rst_sat_cnt", 32'(s_cnt), 8);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_pre_cnt", 32'(p_cnt), 0);
        chk("async_rst_sat_ovf", 32'(s_ovf), 0);
        chk("async_rst_sat_cnt", 32'(s_cnt), 0);
        rst = 1'b0;
        begin
            logic [3:0] exp_after[3];
            exp_after = '{0, 0, 1};
            for (int i = 0; i < 3; i++) begin
                edge_step();
                chk($sformatf("post_rst%0d_cnt", i), 32'(p_cnt), 32'(exp_after[i]));
            end
        end

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_up_down_counter_param

// File: doc/up_down_counter_param.md
UP_DOWN_COUNTER_PARAM -- requirements
Module: up_down_counter_param

Interface
REQ-001 Parameter WIDTH, default 8: counter width in bits, legal range 2..32.
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1: upper count limit; count range is 0..MAX_COUNT; legal range 1..2**WIDTH-1.
REQ-003 Parameter MODE_SAT, default 0: boundary mode; 0 = wrap, 1 = saturate.
REQ-004 Parameter PRESCALE, default 1: number of enabled clock edges per count step; legal range 1..65535.
REQ-005 Clk_In  input  1  system clock; all state updates on its falling edge.
REQ-006 Reset_In  input  1  reset, asynchronous, active-high.
REQ-007 Start_Stopb_In  input  1  1 = counting enabled, 0 = hold.
REQ-008 Up_Downb_In  input  1  1 = count up, 0 = count down.
REQ-009 Clear_In  input  1  synchronous clear of count, prescaler and Overflow_Out.
REQ-010 Load_In  input  1  synchronous parallel load.
REQ-011 Load_Value_In  input  WIDTH  value for the parallel load.
REQ-012 Count_Out  output  WIDTH  registered count value.
REQ-013 Terminal_Count_Out  output  1  registered one-cycle pulse on a boundary event.
REQ-014 Overflow_Out  output  1  registered sticky flag, set on any boundary event.

Function
REQ-015 Per falling edge, priority SHALL be Clear_In > Load_In > count step > hold.
REQ-016 Prescaler: counts falling edges while Start_Stopb_In=1 and no clear or load; a step tick SHALL occur on the edge where the prescaler reaches PRESCALE-1, after which it returns to 0.
REQ-017 The prescaler SHALL hold its value while Start_Stopb_In=0; PRESCALE=1 gives a tick on every enabled edge.
REQ-018 On a tick, Count_Out SHALL update on that same edge (zero added latency); Up_Downb_In is sampled on that edge only.
REQ-019 Up step below MAX_COUNT and down step above 0 SHALL change Count_Out by exactly ±1.
REQ-020 Up step at MAX_COUNT SHALL give 0 (MODE_SAT=0) or hold MAX_COUNT (MODE_SAT=1); either case is a boundary event.
REQ-021 Down step at 0 SHALL give MAX_COUNT (MODE_SAT=0) or hold 0 (MODE_SAT=1); either case is a boundary event.
REQ-022 A boundary event SHALL set Terminal_Count_Out high for exactly one clock and set Overflow_Out until the next clear or reset.
REQ-023 Load SHALL write min(Load_Value_In, MAX_COUNT) to Count_Out, clear the prescaler, and SHALL NOT be a boundary event.
REQ-024 Clear SHALL set Count_Out, the prescaler, Overflow_Out and Terminal_Count_Out to 0, overriding a simultaneous load or tick.
REQ-025 Terminal_Count_Out SHALL be 0 on every edge that has no boundary event.

Reset
REQ-026 Reset_In high SHALL force Count_Out=0, prescaler=0, Terminal_Count_Out=0 and Overflow_Out=0 immediately, independent of Clk_In.
REQ-027 After Reset_In deasserts mid-operation, counting SHALL resume from 0 with a full PRESCALE period before the first tick.

Structure
REQ-028 Package up_down_counter_pkg SHALL hold the MODE_WRAP/MODE_SAT constants and the prescaler width constant (16).
REQ-029 The prescaler SHALL be a sub-module named prescale_tick (inputs: clock, reset, clear, enable; output: tick).
REQ-030 Parameter legality SHALL be checked at elaboration, and illegal values SHALL cause an elaboration error.

Verification
REQ-031 WIDTH=4, MAX_COUNT=9, MODE_SAT=0, PRESCALE=1, counting up from 0 for 10 ticks -> Count_Out 1..9 then 0, one Terminal_Count_Out pulse on the 9->0 edge, Overflow_Out=1.
REQ-032 Same configuration with MODE_SAT=1, counting down from 0 for 3 ticks -> Count_Out stays 0, Terminal_Count_Out pulses 3 times, Overflow_Out=1.
REQ-033 Load_Value_In=12 with MAX_COUNT=9 -> Count_Out=9, no Terminal_Count_Out pulse, Overflow_Out unchanged.
REQ-034 PRESCALE=3 with 6 enabled edges from 0, Start_Stopb_In dropped for 4 edges mid-sequence -> Count_Out=2, held unchanged during the stop.
REQ-035 Clear_In and Load_In asserted on the same edge at Count_Out=5 -> Count_Out=0 and Overflow_Out=0.
REQ-036 Reset_In pulsed between clock edges at Count_Out=7 -> Count_Out=0 with no clock edge, and the next tick comes PRESCALE enabled edges later.
